// File: rtl/game_tick_scheduler.sv
// game_tick_scheduler: single-clock timing controller for the snake game.
// Generates one-cycle clock-enable strobes (pixel, scan, game step), sequences
// stepping through IDLE/RUN/PAUSE/OVER and applies speed changes on step
// boundaries with a request/ack handshake.
// Optional feature: define TICK_TURBO_EN to add the 'turbo' input, which
// halves the step period while high in RUN.
module game_tick_scheduler #(
  parameter int PIX_DIV   = 4,
  parameter int SCAN_DIV  = 1000000,
  parameter int STEP_BASE = 25000000,
  parameter int STEP_DEC  = 2500000,
  parameter int LEVELS    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        pause,
  input  logic        resume,
  input  logic        stop,
  input  logic [2:0]  speed_level,
  input  logic        speed_load,
`ifdef TICK_TURBO_EN
  input  logic        turbo,
`endif
  output logic        speed_ack,
  output logic [2:0]  active_level,
  output logic        pix_en,
  output logic        scan_en,
  output logic        step_en,
  output logic [1:0]  state,
  output logic [15:0] step_count
);

  localparam int PIX_W  = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int STEP_W = $clog2(STEP_BASE + 1);
  localparam logic [2:0] MAX_LEVEL = 3'(LEVELS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_OVER  = 2'b11
  } state_t;

  state_t            state_q, state_d;
  logic [PIX_W-1:0]  pix_cnt_q, pix_cnt_d;
  logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
  logic [STEP_W-1:0] step_cnt_q, step_cnt_d;
  logic              pix_en_q, pix_en_d;
  logic              scan_en_q, scan_en_d;
  logic              step_en_q, step_en_d;
  logic [15:0]       step_count_q, step_count_d;
  logic [2:0]        active_level_q, active_level_d;
  logic [2:0]        pend_level_q, pend_level_d;
  logic              pend_valid_q, pend_valid_d;
  logic              speed_ack_q, speed_ack_d;
  logic              restart, advance, turbo_on;
  logic [31:0]       period, terminal;
  logic [2:0]        load_level;

`ifdef TICK_TURBO_EN
  assign turbo_on = turbo;
`else
  assign turbo_on = 1'b0;
`endif

  // Step terminal count from the active level; turbo halves the period.
  always_comb begin
    period   = 32'(STEP_BASE) - 32'(active_level_q) * 32'(STEP_DEC);
    terminal = turbo_on ? ((period >> 1) - 32'd1) : (period - 32'd1);
  end

  // Free-running pixel and scan dividers, never gated by game state.
  always_comb begin
    pix_cnt_d  = pix_cnt_q + PIX_W'(1);
    pix_en_d   = 1'b0;
    scan_cnt_d = scan_cnt_q + SCAN_W'(1);
    scan_en_d  = 1'b0;
    if (32'(pix_cnt_q) == 32'(PIX_DIV - 1)) begin
      pix_cnt_d = '0;
      pix_en_d  = 1'b1;
    end
    if (32'(scan_cnt_q) == 32'(SCAN_DIV - 1)) begin
      scan_cnt_d = '0;
      scan_en_d  = 1'b1;
    end
  end

  // Next game state; priority stop > pause > start/resume.
  always_comb begin
    state_d = state_q;
    restart = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          restart = 1'b1;
        end
      end
      S_RUN: begin
        if (stop)       state_d = S_OVER;
        else if (pause) state_d = S_PAUSE;
        else if (start) restart = 1'b1;
      end
      S_PAUSE: begin
        if (stop) begin
          state_d = S_OVER;
        end else if (!pause) begin
          if (start) begin
            state_d = S_RUN;
            restart = 1'b1;
          end else if (resume) begin
            state_d = S_RUN;
          end
        end
      end
      S_OVER: begin
        if (!stop && start) begin
          state_d = S_RUN;
          restart = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Counting only continues while the game stays running this cycle.
    advance = (state_q == S_RUN) && (state_d == S_RUN) && !restart;
  end

  // Step period counter and step strobe; >= lets turbo cut a step short.
  always_comb begin
    step_cnt_d   = step_cnt_q;
    step_count_d = step_count_q;
    step_en_d    = 1'b0;
    if (restart) begin
      step_cnt_d   = '0;
      step_count_d = '0;
    end else if (advance) begin
      if (32'(step_cnt_q) >= terminal) begin
        step_cnt_d   = '0;
        step_en_d    = 1'b1;
        step_count_d = step_count_q + 16'd1;
      end else begin
        step_cnt_d = step_cnt_q + STEP_W'(1);
      end
    end
  end

  // Speed handshake: immediate when not running, at step boundary in RUN.
  always_comb begin
    load_level     = (speed_level > MAX_LEVEL) ? MAX_LEVEL : speed_level;
    active_level_d = active_level_q;
    pend_level_d   = pend_level_q;
    pend_valid_d   = pend_valid_q;
    speed_ack_d    = 1'b0;
    if (state_d != S_RUN) begin
      if (speed_load) begin
        active_level_d = load_level;
        speed_ack_d    = 1'b1;
        pend_valid_d   = 1'b0;
      end else if (pend_valid_q) begin
        active_level_d = pend_level_q;
        speed_ack_d    = 1'b1;
        pend_valid_d   = 1'b0;
      end
    end else begin
      // A load arriving with the strobe waits for the following boundary.
      if (step_en_q && pend_valid_q) begin
        active_level_d = pend_level_q;
        speed_ack_d    = 1'b1;
        pend_valid_d   = 1'b0;
      end
      if (speed_load) begin
        pend_level_d = load_level;
        pend_valid_d = 1'b1;
      end
    end
  end

  // All state and registered outputs; synchronous reset clears everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      pix_cnt_q      <= '0;
      scan_cnt_q     <= '0;
      step_cnt_q     <= '0;
      pix_en_q       <= 1'b0;
      scan_en_q      <= 1'b0;
      step_en_q      <= 1'b0;
      step_count_q   <= '0;
      active_level_q <= '0;
      pend_level_q   <= '0;
      pend_valid_q   <= 1'b0;
      speed_ack_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      pix_cnt_q      <= pix_cnt_d;
      scan_cnt_q     <= scan_cnt_d;
      step_cnt_q     <= step_cnt_d;
      pix_en_q       <= pix_en_d;
      scan_en_q      <= scan_en_d;
      step_en_q      <= step_en_d;
      step_count_q   <= step_count_d;
      active_level_q <= active_level_d;
      pend_level_q   <= pend_level_d;
      pend_valid_q   <= pend_valid_d;
      speed_ack_q    <= speed_ack_d;
    end
  end

  assign speed_ack    = speed_ack_q;
  assign active_level = active_level_q;
  assign pix_en       = pix_en_q;
  assign scan_en      = scan_en_q;
  assign step_en      = step_en_q;
  assign state        = state_q;
  assign step_count   = step_count_q;

endmodule

// File: tb/tb_game_tick_scheduler.sv
// Bench for game_tick_scheduler: vector table with hand-derived expectations,
// hand-written corner sequences and a randomized run against a cycle-level
// reference model built from the game rules. Define TICK_TURBO_EN to also
// exercise the turbo input.
module tb_game_tick_scheduler;

  localparam int PIX_DIV   = 4;
  localparam int SCAN_DIV  = 10;
  localparam int STEP_BASE = 20;
  localparam int STEP_DEC  = 2;
  localparam int LEVELS    = 8;

  logic        clk = 1'b0;
  logic        rst, start, pause, resume, stop, speed_load, turbo;
  logic [2:0]  speed_level;
  logic        speed_ack, pix_en, scan_en, step_en;
  logic [2:0]  active_level;
  logic [1:0]  state;
  logic [15:0] step_count;

  always #5 clk = ~clk;

  game_tick_scheduler #(
    .PIX_DIV(PIX_DIV), .SCAN_DIV(SCAN_DIV), .STEP_BASE(STEP_BASE),
    .STEP_DEC(STEP_DEC), .LEVELS(LEVELS)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .resume(resume),
    .stop(stop), .speed_level(speed_level), .speed_load(speed_load),
`ifdef TICK_TURBO_EN
    .turbo(turbo),
`endif
    .speed_ack(speed_ack), .active_level(active_level), .pix_en(pix_en),
    .scan_en(scan_en), .step_en(step_en), .state(state), .step_count(step_count)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: game state, cycles elapsed in the current step, levels.
  int m_n, m_state, m_elapsed, m_level, m_pend, m_pend_lvl, m_count, m_step, m_ack;
  int rec_steps, rec_acks;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit rs, st, pa, re, sp, ld, input int lv, input bit tb);
    int nxt, per, limit, clamp;
    bit restart, fire, ack;
    if (rs) begin
      m_n = 0; m_state = 0; m_elapsed = 0; m_level = 0; m_pend = 0;
      m_pend_lvl = 0; m_count = 0; m_step = 0; m_ack = 0;
    end else begin
      m_n++;
      nxt = m_state;
      restart = 0;
      case (m_state)
        0: if (st) begin nxt = 1; restart = 1; end
        1: if (sp) nxt = 3; else if (pa) nxt = 2; else if (st) restart = 1;
        2: if (sp) nxt = 3;
           else if (!pa) begin
             if (st) begin nxt = 1; restart = 1; end
             else if (re) nxt = 1;
           end
        default: if (!sp && st) begin nxt = 1; restart = 1; end
      endcase
      // A step lasts 'limit' running cycles at the level in force.
      per   = STEP_BASE - m_level * STEP_DEC;
      limit = tb ? per / 2 : per;
      fire  = 0;
      if (restart) begin
        m_elapsed = 0;
        m_count   = 0;
      end else if (m_state == 1 && nxt == 1) begin
        m_elapsed++;
        if (m_elapsed >= limit) begin
          m_elapsed = 0;
          fire      = 1;
          m_count   = (m_count + 1) % 65536;
        end
      end
      clamp = (lv > LEVELS - 1) ? LEVELS - 1 : lv;
      ack = 0;
      if (nxt != 1) begin
        if (ld) begin m_level = clamp; ack = 1; m_pend = 0; end
        else if (m_pend != 0) begin m_level = m_pend_lvl; ack = 1; m_pend = 0; end
      end else begin
        if (m_step != 0 && m_pend != 0) begin m_level = m_pend_lvl; ack = 1; m_pend = 0; end
        if (ld) begin m_pend = 1; m_pend_lvl = clamp; end
      end
      m_state = nxt;
      m_step  = fire;
      m_ack   = ack;
    end
  endtask

  task automatic tick(input bit rs, st, pa, re, sp, ld, input int lv, input bit tb);
    rst = rs; start = st; pause = pa; resume = re; stop = sp;
    speed_load = ld; speed_level = 3'(lv); turbo = tb;
    model_step(rs, st, pa, re, sp, ld, lv, tb);
    @(posedge clk);
    #1;
    check("pix_en", pix_en, (m_n > 0 && m_n % PIX_DIV == 0) ? 1 : 0);
    check("scan_en", scan_en, (m_n > 0 && m_n % SCAN_DIV == 0) ? 1 : 0);
    check("step_en", step_en, m_step);
    check("speed_ack", speed_ack, m_ack);
    check("active_level", active_level, m_level);
    check("state", state, m_state);
    check("step_count", step_count, m_count);
    rec_steps += int'(step_en);
    rec_acks  += int'(speed_ack);
  endtask

  typedef struct {
    bit rs, st, pa, re, sp, ld;
    int lv;
    bit tb;
    int cyc;
    int e_state, e_count, e_level, e_steps, e_acks;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit rs, st, pa, re, sp, ld, int lv, bit tb, int cyc,
                              int es, int ec, int el, int est, int ea);
    vec_t v;
    v.rs = rs; v.st = st; v.pa = pa; v.re = re; v.sp = sp; v.ld = ld;
    v.lv = lv; v.tb = tb; v.cyc = cyc;
    v.e_state = es; v.e_count = ec; v.e_level = el; v.e_steps = est; v.e_acks = ea;
    return v;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int pix_seen, scan_seen, first_pix, waited;
    bit ttb;
    rst = 1'b1; start = 1'b0; pause = 1'b0; resume = 1'b0; stop = 1'b0;
    speed_load = 1'b0; speed_level = 3'd0; turbo = 1'b0;

    // Reset state, then 40 idle cycles of free-running strobes.
    tick(1, 0, 0, 0, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0, 0, 0, 0);
    check("reset state", state, 0);
    check("reset step_count", step_count, 0);
    check("reset active_level", active_level, 0);
    check("reset strobes", {pix_en, scan_en, step_en, speed_ack}, 0);
    pix_seen = 0; scan_seen = 0; first_pix = 0; rec_steps = 0;
    for (int c = 1; c <= 40; c++) begin
      tick(0, 0, 0, 0, 0, 0, 0, 0);
      if (pix_en && first_pix == 0) first_pix = c;
      pix_seen  += int'(pix_en);
      scan_seen += int'(scan_en);
    end
    check("idle first pix cycle", first_pix, 4);
    check("idle pix count", pix_seen, 10);
    check("idle scan count", scan_seen, 4);
    check("idle step count", rec_steps, 0);
    check("idle state", state, 0);
    $display("idle phase: pix=%0d scan=%0d steps=%0d", pix_seen, scan_seen, rec_steps);

    //              rs st pa re sp ld lv tb cyc  state cnt lvl steps acks
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 61, 1, 3, 0, 3, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 5,  1, 3, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 30, 2, 3, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 15, 1, 3, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1,  1, 4, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 7,  1, 4, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 3, 0, 13, 1, 5, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1,  1, 5, 3, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 12, 1, 5, 3, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1,  1, 6, 3, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 14, 1, 7, 3, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 1, 1, 7, 0, 1,  3, 7, 7, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 10, 3, 7, 7, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 1,  1, 0, 7, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 6,  1, 1, 7, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 6,  1, 2, 7, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 3,  1, 0, 7, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 1,  2, 0, 7, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 1,  1, 0, 7, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 1,  3, 0, 7, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 1,  3, 0, 7, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 1,  3, 0, 7, 0, 0));
    // Load coinciding with step_en waits a full extra step.
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 1,  1, 0, 7, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 5,  1, 0, 7, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1,  1, 1, 7, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 5, 0, 1,  1, 1, 7, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 4,  1, 1, 7, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1,  1, 2, 7, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1,  1, 2, 5, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 8,  1, 2, 5, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1,  1, 3, 5, 1, 0));
    // Reset mid-run discards a pending level.
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 1,  1, 0, 5, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 2, 0, 3,  1, 0, 5, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 5,  0, 0, 0, 0, 0));
`ifdef TICK_TURBO_EN
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 15, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1,  1, 1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 10, 1, 2, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 10, 1, 3, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 19, 1, 3, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1,  1, 4, 0, 1, 0));
`endif

    foreach (vecs[i]) begin
      rec_steps = 0;
      rec_acks  = 0;
      for (int c = 0; c < vecs[i].cyc; c++) begin
        if (c == 0)
          tick(vecs[i].rs, vecs[i].st, vecs[i].pa, vecs[i].re, vecs[i].sp,
               vecs[i].ld, vecs[i].lv, vecs[i].tb);
        else
          tick(0, 0, 0, 0, 0, 0, 0, vecs[i].tb);
      end
      check($sformatf("vec%0d state", i), state, vecs[i].e_state);
      check($sformatf("vec%0d step_count", i), step_count, vecs[i].e_count);
      check($sformatf("vec%0d active_level", i), active_level, vecs[i].e_level);
      check($sformatf("vec%0d step pulses", i), rec_steps, vecs[i].e_steps);
      check($sformatf("vec%0d ack pulses", i), rec_acks, vecs[i].e_acks);
      $display("vec%0d: state=%0d count=%0d level=%0d steps=%0d acks=%0d", i,
               state, step_count, active_level, rec_steps, rec_acks);
    end

    // Bounded wait for the first step after a fresh start at level 0.
    tick(1, 0, 0, 0, 0, 0, 0, 0);
    tick(0, 1, 0, 0, 0, 0, 0, 0);
    waited = 0;
    do begin
      tick(0, 0, 0, 0, 0, 0, 0, 0);
      waited++;
    end while (!step_en && waited < 50);
    check("first step latency", waited, 20);
    $display("start to first step: %0d cycles", waited);

    // Randomized traffic against the reference model.
    tick(1, 0, 0, 0, 0, 0, 0, 0);
    ttb = 1'b0;
    for (int c = 0; c < 3000; c++) begin
`ifdef TICK_TURBO_EN
      if ($urandom_range(0, 29) == 0) ttb = ~ttb;
`endif
      tick($urandom_range(0, 499) == 0, $urandom_range(0, 39) == 0,
           $urandom_range(0, 29) == 0, $urandom_range(0, 19) == 0,
           $urandom_range(0, 59) == 0, $urandom_range(0, 24) == 0,
           int'($urandom_range(0, 7)), ttb);
    end
    $display("random phase: final state=%0d count=%0d level=%0d",
             state, step_count, active_level);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
